// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives pause/nop of every pipeline latch and the PC enable.
// Optional performance counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int LOADUSE_BUBBLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             mem_redirect,
    input  logic             mem_halt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    output logic             pc_en,
    output logic             ifid_pause,
    output logic             idex_pause,
    output logic             exmem_pause,
    output logic             memwb_pause,
    output logic             ifid_nop,
    output logic             idex_nop,
    output logic             exmem_nop,
    output logic             memwb_nop,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DWAIT = 2'b01,
        IWAIT = 2'b10,
        HALT  = 2'b11
    } state_e;

    localparam logic [1:0] BUB_INIT = 2'(LOADUSE_BUBBLES - 1);

    // Latch vectors are ordered {ifid, idex, exmem, memwb}.
    localparam logic [3:0] HOLD_PAUSE = 4'b1110;
    localparam logic [3:0] HOLD_NOP   = 4'b0001;

    state_e     state_q, state_d;
    logic       iwait_pend_q, iwait_pend_d;
    logic [1:0] bub_q, bub_d;

    logic       dmiss_s;
    logic       load_use_s;
    logic [3:0] run_pause_s, run_nop_s;
    logic       run_pc_en_s;
    state_e     run_next_s;
    logic [1:0] run_bub_s;

    logic [3:0] pause_s, nop_s;
    logic       pc_en_s, halted_s;

    assign dmiss_s    = dmem_req & ~dhit;
    assign load_use_s = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));

    // RUN priority rules 2..6 (data miss handled by the FSM since it also applies in DWAIT/IWAIT).
    always_comb begin
        run_pause_s = 4'b0000;
        run_nop_s   = 4'b0000;
        run_pc_en_s = 1'b0;
        run_next_s  = RUN;
        run_bub_s   = bub_q;
        if (mem_halt) begin
            run_nop_s  = 4'b1110;
            run_next_s = HALT;
        end else if (mem_redirect) begin
            run_pc_en_s = 1'b1;
            run_nop_s   = 4'b1110;
            run_bub_s   = 2'd0;
            run_next_s  = ihit ? RUN : IWAIT;
        end else if (load_use_s || (bub_q != 2'd0)) begin
            run_pause_s = 4'b1000;
            run_nop_s   = 4'b0100;
            run_bub_s   = (bub_q != 2'd0) ? (bub_q - 2'd1) : BUB_INIT;
        end else if (!ihit) begin
            run_nop_s = 4'b1000;
        end else begin
            run_pc_en_s = 1'b1;
        end
    end

    // Next-state and latch-control outputs per state.
    always_comb begin
        pause_s      = 4'b0000;
        nop_s        = 4'b0000;
        pc_en_s      = 1'b0;
        halted_s     = 1'b0;
        state_d      = state_q;
        iwait_pend_d = iwait_pend_q;
        bub_d        = bub_q;
        case (state_q)
            RUN: begin
                if (dmiss_s) begin
                    pause_s = HOLD_PAUSE;
                    nop_s   = HOLD_NOP;
                    state_d = DWAIT;
                end else begin
                    pause_s = run_pause_s;
                    nop_s   = run_nop_s;
                    pc_en_s = run_pc_en_s;
                    state_d = run_next_s;
                    bub_d   = run_bub_s;
                end
            end
            DWAIT: begin
                if (!dhit) begin
                    pause_s = HOLD_PAUSE;
                    nop_s   = HOLD_NOP;
                end else if (iwait_pend_q && !mem_halt && !mem_redirect) begin
                    nop_s        = 4'b1000;
                    state_d      = ihit ? RUN : IWAIT;
                    iwait_pend_d = 1'b0;
                end else begin
                    // A redirect while a stale fetch is still outstanding must still discard that fetch.
                    pause_s      = run_pause_s;
                    nop_s        = run_nop_s;
                    pc_en_s      = run_pc_en_s;
                    state_d      = (iwait_pend_q && mem_redirect) ? IWAIT : run_next_s;
                    bub_d        = run_bub_s;
                    iwait_pend_d = 1'b0;
                end
            end
            IWAIT: begin
                if (dmiss_s) begin
                    pause_s      = HOLD_PAUSE;
                    nop_s        = HOLD_NOP;
                    state_d      = DWAIT;
                    iwait_pend_d = 1'b1;
                end else begin
                    nop_s   = 4'b1000;
                    state_d = ihit ? RUN : IWAIT;
                end
            end
            HALT: begin
                pause_s  = 4'b1111;
                halted_s = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Drive ports; reset forces bubbles everywhere, and nop always overrides pause.
    always_comb begin
        if (RST) begin
            {ifid_nop, idex_nop, exmem_nop, memwb_nop}         = 4'b1111;
            {ifid_pause, idex_pause, exmem_pause, memwb_pause} = 4'b0000;
            pc_en  = 1'b0;
            halted = 1'b0;
        end else begin
            {ifid_nop, idex_nop, exmem_nop, memwb_nop}         = nop_s;
            {ifid_pause, idex_pause, exmem_pause, memwb_pause} = pause_s & ~nop_s;
            pc_en  = pc_en_s;
            halted = halted_s;
        end
    end

    assign state = state_q;

    // FSM, stale-fetch flag and load-use bubble counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RUN;
            iwait_pend_q <= 1'b0;
            bub_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            iwait_pend_q <= iwait_pend_d;
            bub_q        <= bub_d;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_inc_s, flush_inc_s;

    assign stall_inc_s = ~pc_en_s & (state_q != HALT);
    // Only a taken redirect advances the PC while bubbling EX/MEM.
    assign flush_inc_s = pc_en_s & nop_s[1];

    // Saturating counter increments.
    always_comb begin
        if (stall_inc_s && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
        if (flush_inc_s && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl; observed vector is
// {pc_en, pause[ifid,idex,exmem,memwb], nop[ifid,idex,exmem,memwb], halted, state}.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, dmem_req, mem_redirect, mem_halt, ex_memread;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic        pc_en, ifid_pause, idex_pause, exmem_pause, memwb_pause;
    logic        ifid_nop, idex_nop, exmem_nop, memwb_nop, halted;
    logic [1:0]  state;
    logic [31:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    pipeline_hazard_ctrl #(.LOADUSE_BUBBLES(1), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .mem_redirect(mem_redirect), .mem_halt(mem_halt), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .pc_en(pc_en),
        .ifid_pause(ifid_pause), .idex_pause(idex_pause), .exmem_pause(exmem_pause),
        .memwb_pause(memwb_pause), .ifid_nop(ifid_nop), .idex_nop(idex_nop),
        .exmem_nop(exmem_nop), .memwb_nop(memwb_nop), .halted(halted), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    wire [11:0] obs = {pc_en, ifid_pause, idex_pause, exmem_pause, memwb_pause,
                       ifid_nop, idex_nop, exmem_nop, memwb_nop, halted, state};

    always #5 CLK = ~CLK;

    task drive(input logic rst, input logic ih, input logic dh, input logic dreq,
               input logic redir, input logic hlt);
        RST = rst; ihit = ih; dhit = dh; dmem_req = dreq; mem_redirect = redir; mem_halt = hlt;
    endtask

    task lu(input logic mr, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        ex_memread = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    endtask

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task do_reset;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lu(1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task test_reset;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lu(1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        checks++;
        if (obs[11:2] !== 10'b0_0000_1111_0) begin
            errors++; $display("FAIL reset_c1 got=%b exp=%b", obs[11:2], 10'b0_0000_1111_0);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1111_0_00) begin
            errors++; $display("FAIL reset_c2 got=%b exp=%b", obs, 12'b0_0000_1111_0_00);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_count);
        end
        tick();
    endtask

    task test_load_use;
        do_reset();
        lu(1'b1, 5'd5, 5'd0, 5'd5);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1000_0100_0_00) begin
            errors++; $display("FAIL lu_rt got=%b exp=%b", obs, 12'b0_1000_0100_0_00);
        end
        tick();
        lu(1'b0, 5'd0, 5'd0, 5'd5);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL lu_release got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        tick();
        lu(1'b1, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL lu_r0 got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        tick();
        lu(1'b1, 5'd7, 5'd7, 5'd3);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1000_0100_0_00) begin
            errors++; $display("FAIL lu_rs got=%b exp=%b", obs, 12'b0_1000_0100_0_00);
        end
        tick();
        lu(1'b1, 5'd7, 5'd3, 5'd4);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL lu_nomatch got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        tick();
        lu(1'b0, 5'd7, 5'd7, 5'd7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1000_0_00) begin
            errors++; $display("FAIL imiss got=%b exp=%b", obs, 12'b0_0000_1000_0_00);
        end
        tick();
    endtask

    task test_dmiss;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1110_0001_0_00) begin
            errors++; $display("FAIL dmiss_c1 got=%b exp=%b", obs, 12'b0_1110_0001_0_00);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== 12'b0_1110_0001_0_01) begin
                errors++; $display("FAIL dmiss_wait%0d got=%b exp=%b", i, obs, 12'b0_1110_0001_0_01);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_01) begin
            errors++; $display("FAIL dmiss_release got=%b exp=%b", obs, 12'b1_0000_0000_0_01);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL dmiss_run got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        checks++;
        if (stall_cycles !== 32'(3 * PERF)) begin
            errors++; $display("FAIL dmiss_stall_cnt got=%0d exp=%0d", stall_cycles, 3 * PERF);
        end
        tick();
    endtask

    task test_redirect;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_1110_0_00) begin
            errors++; $display("FAIL redir_miss got=%b exp=%b", obs, 12'b1_0000_1110_0_00);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1000_0_10) begin
            errors++; $display("FAIL iwait got=%b exp=%b", obs, 12'b0_0000_1000_0_10);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1000_0_10) begin
            errors++; $display("FAIL iwait_discard got=%b exp=%b", obs, 12'b0_0000_1000_0_10);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL iwait_exit got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        checks++;
        if (flush_count !== 32'(PERF) || stall_cycles !== 32'(2 * PERF)) begin
            errors++; $display("FAIL redir_cnt got=%0d/%0d exp=%0d/%0d", flush_count, stall_cycles, PERF, 2 * PERF);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lu(1'b1, 5'd9, 5'd9, 5'd0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_1110_0_00) begin
            errors++; $display("FAIL redir_over_lu got=%b exp=%b", obs, 12'b1_0000_1110_0_00);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lu(1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL redir_hit_run got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        tick();
    endtask

    task test_priority;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1110_0001_0_00) begin
            errors++; $display("FAIL prio_c1 got=%b exp=%b", obs, 12'b0_1110_0001_0_00);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1110_0001_0_01) begin
            errors++; $display("FAIL prio_c2 got=%b exp=%b", obs, 12'b0_1110_0001_0_01);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_1110_0_01) begin
            errors++; $display("FAIL prio_dhit_redir got=%b exp=%b", obs, 12'b1_0000_1110_0_01);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00 || flush_count !== 32'(PERF)) begin
            errors++; $display("FAIL prio_after got=%b/%0d exp=%b/%0d", obs, flush_count, 12'b1_0000_0000_0_00, PERF);
        end
        tick();
    endtask

    task test_iwait_dmiss;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_1110_0001_0_10) begin
            errors++; $display("FAIL iwd_enter got=%b exp=%b", obs, 12'b0_1110_0001_0_10);
        end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1000_0_01) begin
            errors++; $display("FAIL iwd_dhit got=%b exp=%b", obs, 12'b0_0000_1000_0_01);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1000_0_10) begin
            errors++; $display("FAIL iwd_resume got=%b exp=%b", obs, 12'b0_0000_1000_0_10);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00) begin
            errors++; $display("FAIL iwd_run got=%b exp=%b", obs, 12'b1_0000_0000_0_00);
        end
        tick();
    endtask

    task test_rst_mid_dwait;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1111_0_01) begin
            errors++; $display("FAIL rst_dwait got=%b exp=%b", obs, 12'b0_0000_1111_0_01);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b1_0000_0000_0_00 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL rst_dwait_run got=%b/%0d exp=%b/0", obs, stall_cycles, 12'b1_0000_0000_0_00);
        end
        tick();
    endtask

    task test_halt;
        int bad;
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        checks++;
        if (obs !== 12'b0_0000_1110_0_00) begin
            errors++; $display("FAIL halt_enter got=%b exp=%b", obs, 12'b0_0000_1110_0_00);
        end
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'(i % 2), 1'(i % 3 == 0), 1'b0);
            @(negedge CLK);
            checks++;
            if (obs !== 12'b0_1111_0000_1_11) begin
                errors++;
                if (bad < 3) $display("FAIL halt_hold%0d got=%b exp=%b", i, obs, 12'b0_1111_0000_1_11);
                bad++;
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 32'(PERF)) begin
            errors++; $display("FAIL halt_stall_cnt got=%0d exp=%0d", stall_cycles, PERF);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dmiss();
        test_redirect();
        test_priority();
        test_iwait_dmiss();
        test_rst_mid_dwait();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
